branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the RV64I execute stage. It accepts one conditional branch at a time from EX over a valid/ready handshake and configures the signed/unsigned comparison from funct3. It evaluates the branch on registered operands, trains a 2-bit-counter branch history table (BHT) and serves fetch-time predictions from it. On a misprediction it holds a redirect to fetch until fetch accepts it.

## Interface
- XLEN, 64: operand and PC width.
- BHT_ENTRIES, 16: number of 2-bit counters; must be a power of two, at least 2.
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, asynchronous, active-high.
- req_valid  in  1: EX presents a branch.
- req_ready  out  1: controller can accept a branch.
- req_pc  in  XLEN: branch PC.
- req_funct3  in  3: branch funct3.
- req_rs1, req_rs2  in  XLEN: comparison operands.
- req_imm  in  XLEN: sign-extended B-immediate.
- req_pred_taken  in  1: prediction fetch used for this branch.
- pred_pc  in  XLEN: fetch lookup PC.
- pred_taken  out  1: combinational BHT prediction for pred_pc.
- redir_valid  out  1: redirect pending.
- redir_ready  in  1: fetch accepts redirect.
- redir_pc  out  XLEN: correct next PC.
- flush  out  1: pipeline flush pulse.
- illegal_br  out  1: pulse on reserved funct3.
- stat_branches  out  32: resolved legal branches.
- stat_mispred  out  32: mispredictions.

## Operation
- States: IDLE, EVAL, REDIR. req_ready = (state == IDLE).
- IDLE: on req_valid, latch pc, funct3, rs1, rs2, imm and pred_taken, then go to EVAL.
- EVAL takes one cycle and computes from the latched values:
  - BrUn = 1 for funct3 110/111, else 0.
  - BrEq and BrLt come from the comparator.
  - taken per funct3: 000 BrEq; 001 !BrEq; 100 BrLt; 101 !BrLt; 110 BrLt; 111 !BrLt.
- Reserved funct3 (010, 011):
  - taken = 0; no BHT update; no stat increment.
  - illegal_br = 1 for the EVAL cycle.
  - The branch is still checked for misprediction against pc+4.
- Next PC:
  - taken: pc + imm.
  - not taken: pc + 4.
  - Both are modulo 2^XLEN (wrap, no overflow flag).
- mispredict = (taken != pred_taken).
  - If mispredict: load redir_pc with the next PC and go to REDIR.
  - Otherwise go to IDLE.
- REDIR: redir_valid = 1. Return to IDLE on the cycle redir_valid && redir_ready. flush = 1 on that same handshake cycle only.
- BHT index = pc[log2(BHT_ENTRIES)+1:2].
  - Reset value of every counter: 2'b01.
  - Update in EVAL for legal branches: saturating +1 if taken, −1 if not. 11 stays 11; 00 stays 00.
  - pred_taken = counter[1] at index(pred_pc), read combinationally.
  - A lookup to the same index in the update cycle returns the pre-update value.
- Stats:
  - stat_branches increments in EVAL for legal funct3.
  - stat_mispred increments in EVAL on mispredict, including reserved funct3.
  - Both wrap at 2^32.

## Timing
- Reset values: state IDLE, req_ready 1, redir_valid 0, redir_pc 0, flush 0, illegal_br 0, stats 0, all BHT counters 01.
- Branch accepted at edge T. EVAL runs in cycle T+1. redir_valid is first high in cycle T+2, registered.
- Throughput: one branch per 2 cycles when correctly predicted.
- While redir_ready is low, redir_valid and redir_pc stay stable and req_ready stays 0. There is no timeout.
- Reset asserted in any state, including REDIR with redir_valid high:
  - Immediately forces IDLE, redir_valid 0 and flush 0.
  - Clears stats and reinitialises the BHT.
  - The in-flight branch is discarded.
- All outputs except pred_taken are registered or derived from the state register only.

## Structure
- DEF package:
  - dw (XLEN-bit word).
  - Branch funct3 enum: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - State enum: IDLE, EVAL, REDIR.
- One natural sub-module, branch_cmp_core: combinational BrEq/BrLt over dw with a BrUn select.
- The BHT is a register array inside branch_ctrl, not a separate block.

## Test plan
- BEQ, rs1=rs2=5, pc=0x1000, imm=0x40, pred_taken=0 → mispredict; redir_valid at T+2 with redir_pc=0x1040; flush on handshake; stat_mispred=1.
- BLT (100) rs1=−1, rs2=1, vs BLTU (110) with the same operands, both with pred_taken=0:
  - BLT: taken → mispredict.
  - BLTU: not taken → no redirect, back in IDLE at T+2.
- Redirect backpressure: hold redir_ready=0 for 5 cycles → redir_valid and redir_pc stable, req_ready=0. flush is asserted only on the single acceptance cycle.
- BHT training: 3 taken branches at pc=0x2000 → pred_taken for pred_pc=0x2000 goes 0→1→1, with the counter saturating at 11. 2 not-taken branches → counter 01, prediction 0.
- Edge cases:
  - funct3=010 → illegal_br pulse, BHT unchanged, stat_branches unchanged.
  - pc=0xFFFF_FFFF_FFFF_FFFC not taken → redir_pc wraps to 0 when pred_taken=1.
- Assert rst during REDIR → redir_valid drops the same cycle; stats are 0; the BHT reads 01 everywhere.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_ctrl_pkg
// Purpose : Shared types and helpers for the branch resolution controller.
// Revision: 1.0 - initial release
// ============================================================================
package branch_ctrl_pkg;

    localparam int DEF_XLEN = 64;

    // Architectural data word
    typedef logic [DEF_XLEN-1:0] dw;

    // Conditional branch funct3 encodings; 010 and 011 are reserved
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EVAL  = 2'b01,
        ST_REDIR = 2'b10
    } br_state_e;

    // True for the six defined branch encodings
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return !(f3 == 3'b010 || f3 == 3'b011);
    endfunction

    // Unsigned compare is selected by BLTU/BGEU
    function automatic logic f3_is_unsigned(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage : branch_ctrl_pkg
`default_nettype wire

// File: rtl/branch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_ctrl_if
// Purpose : EX request, fetch prediction/redirect and statistics bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface branch_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_imm;
    logic            req_pred_taken;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;
    logic            illegal_br;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    // Pipeline side: EX issues branches, fetch looks up and consumes redirects
    modport master (
        output req_valid, req_pc, req_funct3, req_rs1, req_rs2, req_imm,
               req_pred_taken, pred_pc, redir_ready,
        input  req_ready, pred_taken, redir_valid, redir_pc, flush,
               illegal_br, stat_branches, stat_mispred
    );

    // Controller side
    modport slave (
        input  req_valid, req_pc, req_funct3, req_rs1, req_rs2, req_imm,
               req_pred_taken, pred_pc, redir_ready,
        output req_ready, pred_taken, redir_valid, redir_pc, flush,
               illegal_br, stat_branches, stat_mispred
    );

endinterface : branch_ctrl_if
`default_nettype wire

// File: rtl/branch_ctrl_cmp_core.sv
`default_nettype none
// ============================================================================
// Module  : branch_cmp_core
// Purpose : Combinational equal / less-than comparator with signedness select.
// Revision: 1.0 - initial release
// ============================================================================
module branch_cmp_core #(
    parameter int W = 64
) (
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    input  wire logic         br_un_i,
    output logic              br_eq_o,
    output logic              br_lt_o
);

    // Equality is signedness-agnostic; less-than follows br_un_i
    always_comb begin
        br_eq_o = (a_i == b_i);
        br_lt_o = br_un_i ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
    end

endmodule : branch_cmp_core
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_ctrl
// Purpose : RV64I branch resolution, 2-bit BHT training/prediction and
//           misprediction redirect to fetch.
// Revision: 1.0 - initial release
// ============================================================================
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int BHT_ENTRIES = 16      // power of two, >= 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    branch_ctrl_if.slave       bus_io
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_EVAL  = ST_EVAL;
    localparam logic [1:0] S_REDIR = ST_REDIR;

    // BHT index: word-aligned PC bits directly above the byte offset
    function automatic logic [IDX_W-1:0] bht_idx(input logic [XLEN-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [2:0]      f3_q;
    logic            pt_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [31:0]     stat_br_q, stat_mp_q;
    logic [1:0]      bht_q [BHT_ENTRIES];

    logic            w_br_un, w_br_eq, w_br_lt;
    logic            w_legal, w_taken, w_mispred;
    logic [XLEN-1:0] w_next_pc;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]      w_ctr_cur, w_ctr_next;
    logic            w_accept, w_in_eval;

    assign w_br_un   = f3_is_unsigned(f3_q);
    assign w_legal   = f3_is_legal(f3_q);
    assign w_accept  = (state_q == S_IDLE) && bus_io.req_valid;
    assign w_in_eval = (state_q == S_EVAL);

    branch_cmp_core #(.W(XLEN)) u_cmp (
        .a_i     (rs1_q),
        .b_i     (rs2_q),
        .br_un_i (w_br_un),
        .br_eq_o (w_br_eq),
        .br_lt_o (w_br_lt)
    );

    // Branch outcome, target and misprediction from the latched request
    always_comb begin
        w_taken = 1'b0;
        case (f3_q)
            F3_BEQ:  w_taken = w_br_eq;
            F3_BNE:  w_taken = !w_br_eq;
            F3_BLT:  w_taken = w_br_lt;
            F3_BGE:  w_taken = !w_br_lt;
            F3_BLTU: w_taken = w_br_lt;
            F3_BGEU: w_taken = !w_br_lt;
            default: w_taken = 1'b0;   // reserved encodings never take
        endcase
        w_next_pc = w_taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        w_mispred = (w_taken != pt_q);
    end

    // Saturating 2-bit counter step for the branch being resolved
    always_comb begin
        w_upd_idx  = bht_idx(pc_q);
        w_ctr_cur  = bht_q[w_upd_idx];
        w_ctr_next = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus_io.req_valid) state_d = S_EVAL;
            S_EVAL:  state_d = w_mispred ? S_REDIR : S_IDLE;
            S_REDIR: if (bus_io.redir_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Capture the branch request on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
            pt_q  <= 1'b0;
        end else if (w_accept) begin
            pc_q  <= bus_io.req_pc;
            f3_q  <= bus_io.req_funct3;
            rs1_q <= bus_io.req_rs1;
            rs2_q <= bus_io.req_rs2;
            imm_q <= bus_io.req_imm;
            pt_q  <= bus_io.req_pred_taken;
        end
    end

    // Redirect target, held stable until fetch accepts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          redir_pc_q <= '0;
        else if (w_in_eval && w_mispred)  redir_pc_q <= w_next_pc;
    end

    // Resolution statistics; reserved encodings count only as mispredicts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (w_in_eval) begin
            if (w_legal)   stat_br_q <= stat_br_q + 32'd1;
            if (w_mispred) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    // BHT: all counters weakly not-taken after reset, trained by legal branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (w_in_eval && w_legal) begin
            bht_q[w_upd_idx] <= w_ctr_next;
        end
    end

    assign bus_io.req_ready     = (state_q == S_IDLE);
    assign bus_io.redir_valid   = (state_q == S_REDIR);
    assign bus_io.redir_pc      = redir_pc_q;
    assign bus_io.flush         = (state_q == S_REDIR) && bus_io.redir_ready;
    assign bus_io.illegal_br    = w_in_eval && !w_legal;
    assign bus_io.stat_branches = stat_br_q;
    assign bus_io.stat_mispred  = stat_mp_q;
    // Fetch lookup sees the pre-update counter during a same-index update
    assign bus_io.pred_taken    = bht_q[bht_idx(bus_io.pred_pc)][1];

endmodule : branch_ctrl
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_ctrl
// Purpose : Directed self-checking bench for branch_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_ctrl_if #(.XLEN(64)) bif ();

    branch_ctrl #(.XLEN(64), .BHT_ENTRIES(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bif.slave)
    );

    // Values captured by run_br during EVAL (e_*) and two cycles after accept (r_*)
    logic e_ill, e_rv, e_rdy, e_pred;
    logic r_valid, r_flush, r_rdy, r_ill;
    logic [63:0] r_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic [63:0] pc, input logic exp);
        bif.pred_pc = pc;
        #1;
        chk(tag, {63'd0, bif.pred_taken}, {63'd0, exp});
    endtask

    // Issue one branch; return in IDLE, or in REDIR when redir_ready is low
    task automatic run_br(input logic [63:0] pc, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] imm, input logic pt);
        @(negedge clk);
        bif.req_pc = pc; bif.req_funct3 = f3; bif.req_rs1 = a; bif.req_rs2 = b;
        bif.req_imm = imm; bif.req_pred_taken = pt; bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        e_ill = bif.illegal_br; e_rv = bif.redir_valid; e_rdy = bif.req_ready;
        e_pred = bif.pred_taken;
        @(posedge clk); #1;
        r_valid = bif.redir_valid; r_pc = bif.redir_pc; r_flush = bif.flush;
        r_rdy = bif.req_ready; r_ill = bif.illegal_br;
        if (r_valid && bif.redir_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bif.req_valid = 1'b0; bif.req_pc = '0; bif.req_funct3 = '0;
        bif.req_rs1 = '0; bif.req_rs2 = '0; bif.req_imm = '0;
        bif.req_pred_taken = 1'b0; bif.pred_pc = 64'h1000; bif.redir_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_req_ready",   bif.req_ready, 1);
        chk("rst_redir_valid", bif.redir_valid, 0);
        chk("rst_redir_pc",    bif.redir_pc, 0);
        chk("rst_flush",       bif.flush, 0);
        chk("rst_illegal",     bif.illegal_br, 0);
        chk("rst_stat_br",     bif.stat_branches, 0);
        chk("rst_stat_mp",     bif.stat_mispred, 0);
        chk("rst_pred",        bif.pred_taken, 0);
        @(negedge clk); rst = 1'b0;

        // BEQ taken, predicted not taken: redirect to 0x1040
        run_br(64'h1000, 3'b000, 64'd5, 64'd5, 64'h40, 1'b0);
        chk("beq_eval_rdy",   e_rdy, 0);
        chk("beq_eval_rv",    e_rv, 0);
        chk("beq_eval_ill",   e_ill, 0);
        chk("beq_rv_t2",      r_valid, 1);
        chk("beq_rpc",        r_pc, 64'h1040);
        chk("beq_flush",      r_flush, 1);
        chk("beq_idle_after", bif.req_ready, 1);
        chk("beq_flush_off",  bif.flush, 0);
        chk("beq_stat_mp",    bif.stat_mispred, 1);
        chk("beq_stat_br",    bif.stat_branches, 1);

        // BLT -1 < 1 signed: taken, mispredict to 0x1124
        run_br(64'h1104, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0);
        chk("blt_rv",  r_valid, 1);
        chk("blt_rpc", r_pc, 64'h1124);

        // BLTU same operands: not taken, correctly predicted
        run_br(64'h1108, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0);
        chk("bltu_rv",    r_valid, 0);
        chk("bltu_rdy",   r_rdy, 1);
        chk("bltu_st_br", bif.stat_branches, 3);
        chk("bltu_st_mp", bif.stat_mispred, 2);

        // Redirect backpressure: BNE taken, fetch stalls for 5 cycles
        bif.redir_ready = 1'b0;
        run_br(64'h1200, 3'b001, 64'd1, 64'd2, 64'h100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv",    bif.redir_valid, 1);
            chk("bp_rpc",   bif.redir_pc, 64'h1300);
            chk("bp_rdy",   bif.req_ready, 0);
            chk("bp_flush", bif.flush, 0);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        bif.redir_ready = 1'b1;
        #1;
        chk("bp_flush_hs", bif.flush, 1);
        @(posedge clk); #1;
        chk("bp_flush_after", bif.flush, 0);
        chk("bp_rv_after",    bif.redir_valid, 0);
        chk("bp_rdy_after",   bif.req_ready, 1);
        chk("bp_st_br",       bif.stat_branches, 4);
        chk("bp_st_mp",       bif.stat_mispred, 3);

        // Reserved funct3 010, predicted taken: illegal pulse, redirect to pc+4
        run_br(64'h1304, 3'b010, 64'd9, 64'd9, 64'h8, 1'b1);
        chk("rsv_ill_eval", e_ill, 1);
        chk("rsv_ill_t2",   r_ill, 0);
        chk("rsv_rv",       r_valid, 1);
        chk("rsv_rpc",      r_pc, 64'h1308);
        chk("rsv_st_br",    bif.stat_branches, 4);
        chk("rsv_st_mp",    bif.stat_mispred, 4);
        chk_pred("rsv_bht_kept", 64'h1304, 1'b1);
        chk_pred("bltu_bht_dec", 64'h1108, 1'b0);

        // BGE 0 >= 1 false at top of address space: pc+4 wraps to 0
        run_br(64'hFFFF_FFFF_FFFF_FFFC, 3'b101, 64'd0, 64'd1, 64'h40, 1'b1);
        chk("wrap_rv",    r_valid, 1);
        chk("wrap_rpc",   r_pc, 64'h0);
        chk("wrap_st_br", bif.stat_branches, 5);
        chk("wrap_st_mp", bif.stat_mispred, 5);

        // Reset while a redirect is pending
        bif.redir_ready = 1'b0;
        run_br(64'h3000, 3'b000, 64'd7, 64'd7, 64'h10, 1'b0);
        chk("pre_rst_rv", r_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_rv",    bif.redir_valid, 0);
        chk("arst_flush", bif.flush, 0);
        chk("arst_rdy",   bif.req_ready, 1);
        chk("arst_st_br", bif.stat_branches, 0);
        chk("arst_st_mp", bif.stat_mispred, 0);
        chk("arst_rpc",   bif.redir_pc, 0);
        chk_pred("arst_bht1", 64'h1104, 1'b0);
        @(negedge clk); rst = 1'b0; bif.redir_ready = 1'b1;

        // BHT training at 0x2000: 01 -> 10 -> 11 -> 11, then 10 -> 01
        bif.pred_pc = 64'h2000;
        #1;
        chk("bht_init", bif.pred_taken, 0);
        run_br(64'h2000, 3'b000, 64'd3, 64'd3, 64'h80, 1'b0);
        chk("bht_pre_update", e_pred, 0);
        chk("bht_t1", bif.pred_taken, 1);
        run_br(64'h2000, 3'b000, 64'd3, 64'd3, 64'h80, 1'b1);
        chk("bht_t2", bif.pred_taken, 1);
        run_br(64'h2000, 3'b000, 64'd3, 64'd3, 64'h80, 1'b1);
        chk("bht_t3", bif.pred_taken, 1);
        run_br(64'h2000, 3'b001, 64'd3, 64'd3, 64'h80, 1'b1);
        chk("bht_nt_rpc", r_pc, 64'h2004);
        chk("bht_n1", bif.pred_taken, 1);
        run_br(64'h2000, 3'b001, 64'd3, 64'd3, 64'h80, 1'b1);
        chk("bht_n2", bif.pred_taken, 0);
        chk("train_st_br", bif.stat_branches, 5);
        chk("train_st_mp", bif.stat_mispred, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_ctrl
`default_nettype wire
